// File: rtl/spram_arbiter_if.sv
// Bus bundle between the address decoder, the DMA requester and the SPRAM bank.
// slave = arbiter side, master = requesters plus SPRAM side.
`timescale 1ns/1ps
interface spram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              cpu_phase;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_phase, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_rvalid,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata, dma_rvalid,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_phase, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_rvalid,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata, dma_rvalid,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/spram_arbiter.sv
// Shares one 32K x 8 SPRAM between the 65C02 (one access per cpu_clk low phase) and a DMA port.
// Optional ARB_STATS_EN adds dma_stall_cnt, a saturating count of DMA cycles lost to the CPU.
`timescale 1ns/1ps
module spram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    spram_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]    dma_stall_cnt
`endif
);

    // Read tags ride alongside the SPRAM latency so each read returns to its owner.
    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_CPU  = 2'd1;
    localparam logic [1:0] TAG_DMA  = 2'd2;

    logic              phase_q;
    logic              served;
    logic              cpu_elig;
    logic              dma_grant;
    logic              acc_valid;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [1:0]        acc_tag;
    logic [1:0]        tag_acc;
    logic [1:0]        tag_smp;

    assign cpu_elig  = !bus.cpu_phase && bus.cpu_req && !served;
    assign dma_grant = !cpu_elig && bus.dma_req;

    always_comb begin
        acc_valid = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = bus.dma_addr;
        acc_wdata = bus.dma_wdata;
        acc_tag   = TAG_NONE;
        if (cpu_elig) begin
            acc_valid = 1'b1;
            acc_we    = bus.cpu_we;
            acc_addr  = bus.cpu_addr;
            acc_wdata = bus.cpu_wdata;
            acc_tag   = bus.cpu_we ? TAG_NONE : TAG_CPU;
        end else if (dma_grant) begin
            acc_valid = 1'b1;
            acc_we    = bus.dma_we;
            acc_tag   = bus.dma_we ? TAG_NONE : TAG_DMA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 1'b1;
            served  <= 1'b0;
        end else begin
            phase_q <= bus.cpu_phase;
            if (!phase_q && bus.cpu_phase) begin
                served <= 1'b0;
            end else if (cpu_elig) begin
                served <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ram_addr  <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;
            bus.dma_ack   <= 1'b0;
        end else begin
            bus.dma_ack <= dma_grant;
            bus.ram_we  <= acc_we;
            if (acc_valid) begin
                bus.ram_addr  <= acc_addr;
                bus.ram_wdata <= acc_wdata;
            end
        end
    end

    // tag_acc: ram regs loaded; tag_smp: SPRAM has sampled, data is on ram_rdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_acc <= TAG_NONE;
            tag_smp <= TAG_NONE;
        end else begin
            tag_acc <= acc_tag;
            tag_smp <= tag_acc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.cpu_rdata  <= '0;
            bus.cpu_rvalid <= 1'b0;
            bus.dma_rdata  <= '0;
            bus.dma_rvalid <= 1'b0;
        end else begin
            bus.cpu_rvalid <= (tag_smp == TAG_CPU);
            bus.dma_rvalid <= (tag_smp == TAG_DMA);
            if (tag_smp == TAG_CPU) begin
                bus.cpu_rdata <= bus.ram_rdata;
            end
            if (tag_smp == TAG_DMA) begin
                bus.dma_rdata <= bus.ram_rdata;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_stall_cnt <= 16'h0000;
        end else if (bus.dma_req && cpu_elig && (dma_stall_cnt != 16'hFFFF)) begin
            dma_stall_cnt <= dma_stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed + randomized bench for spram_arbiter with a transaction-level reference model.
`timescale 1ns/1ps
module tb_spram_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    spram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef ARB_STATS_EN
    logic [15:0] dma_stall_cnt;
`endif

    spram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef ARB_STATS_EN
        ,
        .dma_stall_cnt (dma_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // SPRAM: 1-cycle synchronous read
    logic [7:0] mem [0:32767] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    // reference model state
    typedef struct {
        int         due;
        bit         to_cpu;
        logic [7:0] data;
    } resp_t;

    logic [7:0]  shadow [0:32767] = '{default: 8'h00};
    resp_t       rq [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          edge_no = 0;
    int          phase_cnt = 0;
    bit          m_done = 0;
    logic [14:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_cpu_rdata = '0;
    logic [7:0]  m_dma_rdata = '0;
    int          m_stall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit         cpu_win, dma_win, win, we;
        logic [14:0] a;
        logic [7:0]  wd;
        bit         exp_cv, exp_dv;
        int         e;
        e = edge_no;
        // CPU gets one access per low phase; a high phase re-arms it
        cpu_win = !bus.cpu_phase && bus.cpu_req && !m_done;
        dma_win = !cpu_win && bus.dma_req;
        if (bus.cpu_phase) m_done = 0;
        if (cpu_win) m_done = 1;
        if (bus.dma_req && cpu_win && m_stall < 65535) m_stall++;
        win = cpu_win || dma_win;
        we  = cpu_win ? bus.cpu_we : bus.dma_we;
        a   = cpu_win ? bus.cpu_addr : bus.dma_addr;
        wd  = cpu_win ? bus.cpu_wdata : bus.dma_wdata;
        if (win) begin
            m_addr  = a;
            m_wdata = wd;
            if (we) shadow[a] = wd;
            else rq.push_back('{due: e + 2, to_cpu: cpu_win, data: shadow[a]});
        end
        @(posedge clk);
        #1;
        edge_no = e + 1;
        exp_cv = 0;
        exp_dv = 0;
        if (rq.size() > 0 && rq[0].due == e) begin
            if (rq[0].to_cpu) begin exp_cv = 1; m_cpu_rdata = rq[0].data; end
            else begin exp_dv = 1; m_dma_rdata = rq[0].data; end
            void'(rq.pop_front());
        end
        chk("dma_ack", bus.dma_ack, dma_win);
        chk("ram_we", bus.ram_we, win && we);
        chk("ram_addr", bus.ram_addr, m_addr);
        chk("ram_wdata", bus.ram_wdata, m_wdata);
        chk("cpu_rvalid", bus.cpu_rvalid, exp_cv);
        chk("dma_rvalid", bus.dma_rvalid, exp_dv);
        chk("cpu_rdata", bus.cpu_rdata, m_cpu_rdata);
        chk("dma_rdata", bus.dma_rdata, m_dma_rdata);
`ifdef ARB_STATS_EN
        chk("dma_stall_cnt", dma_stall_cnt, m_stall);
`endif
        phase_cnt = (phase_cnt + 1) % 16;
        bus.cpu_phase = (phase_cnt >= 8);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rq.delete();
        m_done = 0;
        m_addr = '0;
        m_wdata = '0;
        m_cpu_rdata = '0;
        m_dma_rdata = '0;
        m_stall = 0;
        #1;
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
        chk("rst_dma_ack", bus.dma_ack, 0);
        chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("rst_dma_rvalid", bus.dma_rvalid, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_dma_rdata", bus.dma_rdata, 0);
`ifdef ARB_STATS_EN
        chk("rst_stall", dma_stall_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        edge_no += 2;
        chk("rst_hold_dma_rvalid", bus.dma_rvalid, 0);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    endtask

    task automatic wait_phase(input int target);
        for (int k = 0; k < 16 && phase_cnt != target; k++) step();
    endtask

    initial begin
        int n;
        idle_inputs();
        bus.cpu_phase = 0;
        #3;
        do_reset();
        repeat (2) step();

        // reset in the middle of a DMA read
        wait_phase(8);
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 15'h0005;
        step();
        bus.dma_req = 0;
        step();
        do_reset();
        repeat (3) step();
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 15'h0005; bus.dma_wdata = 8'h5C;
        step();
        bus.dma_we = 0;
        step();
        bus.dma_req = 0;
        repeat (3) step();

        // CPU write then read back in the next low phase
        wait_phase(0);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 15'h0123; bus.cpu_wdata = 8'hA5;
        step();
        bus.cpu_req = 0; bus.cpu_we = 0;
        wait_phase(0);
        bus.cpu_req = 1;
        step();
        bus.cpu_req = 0;
        repeat (2) step();
        chk("cpu_read_a5", bus.cpu_rdata, 8'hA5);
        chk("cpu_read_valid", bus.cpu_rvalid, 1);

        // contention: CPU first, DMA on the following edge
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 15'h0030;
        wait_phase(0);
        bus.cpu_req = 1; bus.cpu_addr = 15'h0031;
        step();
        chk("contend_no_ack", bus.dma_ack, 0);
        bus.cpu_req = 0;
        step();
        chk("contend_ack_next", bus.dma_ack, 1);
        bus.dma_req = 0;
        repeat (3) step();

        // repeat suppression over two full cpu_clk periods
        wait_phase(0);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 15'h0040; bus.cpu_wdata = 8'h3C;
        for (int p = 0; p < 2; p++) begin
            n = 0;
            for (int k = 0; k < 16; k++) begin
                step();
                if (bus.ram_we) n++;
            end
            chk("one_access_per_phase", n, 1);
        end
        idle_inputs();

        // back-to-back DMA read then CPU read
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 15'h0010; bus.dma_wdata = 8'h11;
        step();
        bus.dma_addr = 15'h0020; bus.dma_wdata = 8'h22;
        step();
        bus.dma_req = 0; bus.dma_we = 0;
        wait_phase(15);
        bus.dma_req = 1; bus.dma_addr = 15'h0010;
        step();
        bus.dma_req = 0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h0020;
        step();
        bus.cpu_req = 0;
        step();
        chk("b2b_dma_data", bus.dma_rdata, 8'h11);
        chk("b2b_dma_only", bus.cpu_rvalid, 0);
        step();
        chk("b2b_cpu_data", bus.cpu_rdata, 8'h22);
        chk("b2b_cpu_only", bus.dma_rvalid, 0);
        idle_inputs();

        // continuous DMA with CPU idle
        n = 0;
        bus.dma_req = 1; bus.dma_we = 0;
        for (int k = 0; k < 16; k++) begin
            bus.dma_addr = 15'h0100 + 15'(k);
            step();
            if (bus.dma_ack) n++;
        end
        chk("dma_stream_acks", n, 16);
        idle_inputs();
        repeat (3) step();

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            bus.cpu_req   = ($urandom % 3) == 0;
            bus.cpu_we    = $urandom % 2;
            bus.cpu_addr  = 15'($urandom % 64);
            bus.cpu_wdata = 8'($urandom);
            bus.dma_req   = ($urandom % 2) == 0;
            bus.dma_we    = ($urandom % 3) == 0;
            bus.dma_addr  = 15'($urandom % 64);
            bus.dma_wdata = 8'($urandom);
            step();
        end
        idle_inputs();
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
